tx_pkt_sched: RTL

Packet scheduler sitting in front of the GMII transmitter on `tx_clk`. Each inter-frame slot, it picks one frame type: video line, audio-only, or video with one piggybacked aux block. It hands the transmitter a registered start pulse with type and aux sizing, then tracks the frame through busy and inter-frame gap before it arbitrates again. A starvation limit keeps back-to-back video lines from locking audio out.

---
 rtl/tx_pkt_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/tx_pkt_sched.sv
// Per-slot frame scheduler for the GMII transmitter: arbitrates video/audio/vidax,
// issues a registered start pulse and tracks the frame through busy and inter-frame gap.
module tx_pkt_sched #(
  parameter logic [11:0] AUX_SIZE      = 12'd50,
  parameter logic [4:0]  AUDIO_MAX     = 5'd20,
  parameter logic [2:0]  VID_RUN_MAX   = 3'd4,
  parameter logic [7:0]  START_TIMEOUT = 8'd64,
  parameter logic [4:0]  GAP_CYCLES    = 5'd12
) (
  input  logic        tx_clk,
  input  logic        sys_rst,
  input  logic        vid_empty,
  input  logic        vid_enable,
  input  logic        aux_empty,
  input  logic        adesig,
  input  logic [3:0]  ade_num,
  input  logic        vidax_en,
  input  logic        tx_busy,
  output logic        pkt_start,
  output logic [1:0]  pkt_type,
  output logic [4:0]  aux_cnt,
  output logic [11:0] aux_bytes,
  output logic [15:0] pkts_sent,
  output logic        err_timeout
);

  typedef enum logic [1:0] {StIdle, StWaitStart, StBusy, StGap} state_e;

  state_e      state_q;
  logic [2:0]  vid_run_q;
  logic [7:0]  to_cnt_q;
  logic [4:0]  gap_cnt_q;

  logic        vreq, areq;
  logic        grant;
  logic [4:0]  ade_inc;
  logic [1:0]  grant_type;
  logic [4:0]  grant_cnt;
  logic [11:0] grant_bytes;
  logic [2:0]  grant_run;

  assign vreq    = ~vid_empty & vid_enable;
  assign areq    = ~aux_empty & adesig;
  assign ade_inc = {1'b0, ade_num} + 5'd1;
  assign grant   = vreq | areq;

  always_comb begin
    grant_type = 2'b00;
    grant_cnt  = 5'd0;
    grant_run  = 3'd0;
    if (vreq && areq && vidax_en) begin
      grant_type = 2'b10;
      grant_cnt  = 5'd1;
    end else if (areq && (!vreq || vid_run_q == VID_RUN_MAX)) begin
      grant_type = 2'b01;
      grant_cnt  = (ade_inc > AUDIO_MAX) ? AUDIO_MAX : ade_inc;
    end else begin
      // Video: count consecutive grants so pending audio is eventually forced in.
      grant_run = (vid_run_q == VID_RUN_MAX) ? vid_run_q : vid_run_q + 3'd1;
    end
  end

  assign grant_bytes = AUX_SIZE * {7'd0, grant_cnt};

  always_ff @(posedge tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      vid_run_q   <= 3'd0;
      to_cnt_q    <= 8'd0;
      gap_cnt_q   <= 5'd0;
      pkt_start   <= 1'b0;
      pkt_type    <= 2'b00;
      aux_cnt     <= 5'd0;
      aux_bytes   <= 12'd0;
      pkts_sent   <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      pkt_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            pkt_start <= 1'b1;
            pkt_type  <= grant_type;
            aux_cnt   <= grant_cnt;
            aux_bytes <= grant_bytes;
            vid_run_q <= grant_run;
            to_cnt_q  <= 8'd0;
            state_q   <= StWaitStart;
          end
        end
        StWaitStart: begin
          if (tx_busy) begin
            state_q <= StBusy;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
            if (to_cnt_q == START_TIMEOUT - 8'd1) begin
              err_timeout <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StBusy: begin
          if (!tx_busy) begin
            pkts_sent <= pkts_sent + 16'd1;
            gap_cnt_q <= 5'd0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          gap_cnt_q <= gap_cnt_q + 5'd1;
          if (gap_cnt_q == GAP_CYCLES - 5'd1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
